cr_cceip_64_sa_rbus_reader: RTL and testbench
=============================================

Name: cr_cceip_64_sa_rbus_reader

Overview:
- Rbus initiator that fetches one 50-bit SA statistic (snapshot or live count) from a remote SA register block over the rbus ring.
- Performs the indirect-access sequence: write IA_CONFIG (read op plus entry index), poll IA_STATUS until not busy, read RDATA part0 and part1.
- Returns the assembled value on a valid/ready-style response port.
- Sits on the initiating end of the ring, feeding telemetry/debug logic.

Parameters:
- N_RBUS_ADDR_BITS, 20, rbus address width.
- SNAP_BASE, 20'h00100, byte address of SA_SNAPSHOT_IA_CONFIG.
- COUNT_BASE, 20'h00120, byte address of SA_COUNT_IA_CONFIG.
- ACK_TIMEOUT, 255, max cycles waiting for ack/err_ack per rbus access (8-bit counter).
- POLL_MAX, 15, max IA_STATUS reads per request before giving up.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: block idle, accepts request.
- req_sel, in, 1: 0 = snapshot, 1 = live count.
- req_idx, in, 6: SA entry 0..63.
- resp_valid, out, 1: response held until resp_ready.
- resp_ready, in, 1: consumer accepts response.
- resp_data, out, 50: {part1[17:0], part0[31:0]}.
- resp_err, out, 2: 0 ok, 1 err_ack, 2 ack timeout, 3 poll limit.
- rbus_addr_o, out, N_RBUS_ADDR_BITS: access address.
- rbus_wr_strb_o, out, 1: one-cycle write strobe.
- rbus_wr_data_o, out, 32: write data.
- rbus_rd_strb_o, out, 1: one-cycle read strobe.
- rbus_rd_data_i, in, 32: read data, valid with ack.
- rbus_ack_i, in, 1: access complete.
- rbus_err_ack_i, in, 1: access failed.

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_err=0; strobes=0; rbus_addr_o=0; rbus_wr_data_o=0; counters=0.
- Address map relative to base B (B = SNAP_BASE if sel=0, else COUNT_BASE; sel and idx latched at accept):
  - CONFIG = B+0
  - STATUS = B+4
  - RDATA0 = B+8
  - RDATA1 = B+12
- CONFIG write data: bits[31:28] = op 4'h1 (read), bits[5:0] = idx, all other bits 0.
- STATUS code field: bits[31:29]. 3'd0 = ready; any other value = busy.
- Accept: req_valid & req_ready in IDLE. req_ready drops the next cycle and stays 0 until the response handshake completes.
- Per-access protocol:
  - ISSUE cycle: exactly one strobe high for one cycle. rbus_addr_o/rbus_wr_data_o are driven that cycle and held through WAIT.
  - WAIT: count cycles. Ack accepted from the cycle after ISSUE onward.
  - err_ack has priority over ack when both are high in the same cycle.
  - ACK_TIMEOUT cycles without ack or err_ack -> timeout.
- FSM transitions (each state is an ISSUE+WAIT pair):
  - IDLE -> WR_CFG on accept.
  - WR_CFG --ack--> RD_STAT.
  - RD_STAT --ack, code=0--> RD_D0.
  - RD_STAT --ack, code!=0--> RD_STAT again, poll_cnt+1. If poll_cnt reaches POLL_MAX -> RESP with err=3.
  - RD_D0 --ack--> capture rd_data into lower[31:0], go to RD_D1.
  - RD_D1 --ack--> capture rd_data[17:0] into upper (bits [31:18] ignored), go to RESP with err=0.
  - Any state on err_ack -> RESP with err=1, resp_data=0.
  - Any state on timeout -> RESP with err=2, resp_data=0.
  - RESP: resp_valid=1 with data/err stable; on resp_ready -> IDLE (resp_valid=0, req_ready=1 next cycle).
- Latency, zero-wait responder (ack the cycle after strobe) and status ready at first poll: 8 cycles from accept to resp_valid.
- A stray ack while in IDLE or RESP is ignored.
- Only one access is outstanding at any time. Strobes are never asserted while WAITing.
- Reset mid-transaction aborts immediately; no further strobes are issued after reset deasserts until a new request.

Test Plan:
- Snapshot read, sel=0 idx=5, responder acks after 1 cycle, status=0, RDATA0=32'hDEADBEEF, RDATA1=32'hFFFC0003 -> CONFIG write to 20'h00100 with data 32'h10000005; resp_data=50'h3_DEADBEEF; err=0; resp_valid 8 cycles after accept.
- Count read, idx=63, status busy for 3 polls then ready -> 4 STATUS reads at 20'h00124, CONFIG data 32'h1000003F, err=0.
- Status busy forever -> exactly 15 STATUS reads, then resp_err=3, resp_data=0.
- No ack on CONFIG write -> resp_err=2 after 255 WAIT cycles; no further strobes are issued.
- err_ack and ack asserted together on RDATA0 -> resp_err=1. Separately, holding resp_ready=0 for 10 cycles keeps resp_valid/data stable and req_ready=0.
- Assert rst during RD_STAT WAIT -> all outputs return to reset values asynchronously; a new request after reset runs cleanly with err=0.

Source files
------------

// File: rtl/cr_cceip_64_sa_rbus_reader.sv
// Rbus initiator that fetches one 50-bit SA statistic through the
// indirect-access registers: write IA_CONFIG, poll IA_STATUS, read RDATA0/1.
// Each access is an ISSUE cycle (one strobe) followed by a WAIT for ack.
module cr_cceip_64_sa_rbus_reader #(
  parameter int unsigned N_RBUS_ADDR_BITS = 20,
  parameter logic [N_RBUS_ADDR_BITS-1:0] SNAP_BASE  = 20'h00100,
  parameter logic [N_RBUS_ADDR_BITS-1:0] COUNT_BASE = 20'h00120,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned POLL_MAX    = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_sel,
  input  logic [5:0]                  req_idx,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [49:0]                 resp_data,
  output logic [1:0]                  resp_err,
  output logic [N_RBUS_ADDR_BITS-1:0] rbus_addr_o,
  output logic                        rbus_wr_strb_o,
  output logic [31:0]                 rbus_wr_data_o,
  output logic                        rbus_rd_strb_o,
  input  logic [31:0]                 rbus_rd_data_i,
  input  logic                        rbus_ack_i,
  input  logic                        rbus_err_ack_i
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_CFG  = 3'd1;
  localparam logic [2:0] S_RD_STAT = 3'd2;
  localparam logic [2:0] S_RD_D0   = 3'd3;
  localparam logic [2:0] S_RD_D1   = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [1:0] E_OK   = 2'd0;
  localparam logic [1:0] E_ERR  = 2'd1;
  localparam logic [1:0] E_TMO  = 2'd2;
  localparam logic [1:0] E_POLL = 2'd3;

  logic [2:0]                  state_q, state_d;
  logic                        wait_q, wait_d;     // 0: issue cycle, 1: waiting for ack
  logic [7:0]                  tmo_q, tmo_d;
  logic [PW-1:0]               poll_q, poll_d;     // busy STATUS reads seen so far
  logic                        sel_q, sel_d;
  logic [5:0]                  idx_q, idx_d;
  logic [31:0]                 lo_q, lo_d;
  logic [17:0]                 hi_q, hi_d;
  logic [1:0]                  err_q, err_d;
  logic [N_RBUS_ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic                        wr_strb_q, wr_strb_d;
  logic                        rd_strb_q, rd_strb_d;

  logic                        issue;
  logic [N_RBUS_ADDR_BITS-1:0] base, off;

  // Next-state: sequence the four accesses, resolve ack/err_ack/timeout
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    poll_d    = poll_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_strb_d = 1'b0;
    rd_strb_d = 1'b0;
    issue     = 1'b0;
    off       = '0;
    base      = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sel_d   = req_sel;
          idx_d   = req_idx;
          poll_d  = '0;
          lo_d    = '0;
          hi_d    = '0;
          err_d   = E_OK;
          state_d = S_WR_CFG;
          issue   = 1'b1;
        end
      end
      S_WR_CFG, S_RD_STAT, S_RD_D0, S_RD_D1: begin
        if (!wait_q) begin
          // ack in the issue cycle itself is not ours yet
          wait_d = 1'b1;
        end else if (rbus_err_ack_i) begin
          state_d = S_RESP;
          err_d   = E_ERR;
          lo_d    = '0;
          hi_d    = '0;
        end else if (rbus_ack_i) begin
          case (state_q)
            S_WR_CFG: begin
              state_d = S_RD_STAT;
              issue   = 1'b1;
            end
            S_RD_STAT: begin
              if (rbus_rd_data_i[31:29] == 3'd0) begin
                state_d = S_RD_D0;
                issue   = 1'b1;
              end else if (poll_q == PW'(POLL_MAX - 1)) begin
                state_d = S_RESP;
                err_d   = E_POLL;
              end else begin
                poll_d = poll_q + PW'(1);
                issue  = 1'b1;
              end
            end
            S_RD_D0: begin
              lo_d    = rbus_rd_data_i;
              state_d = S_RD_D1;
              issue   = 1'b1;
            end
            default: begin
              hi_d    = rbus_rd_data_i[17:0];
              state_d = S_RESP;
              err_d   = E_OK;
            end
          endcase
        end else if (tmo_q == 8'(ACK_TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = E_TMO;
          lo_d    = '0;
          hi_d    = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Launch the access belonging to the state being entered
    if (issue) begin
      base = sel_d ? COUNT_BASE : SNAP_BASE;
      case (state_d)
        S_RD_STAT: off = N_RBUS_ADDR_BITS'(4);
        S_RD_D0:   off = N_RBUS_ADDR_BITS'(8);
        S_RD_D1:   off = N_RBUS_ADDR_BITS'(12);
        default:   off = '0;
      endcase
      wait_d    = 1'b0;
      tmo_d     = '0;
      addr_d    = base + off;
      wr_strb_d = (state_d == S_WR_CFG);
      rd_strb_d = (state_d != S_WR_CFG);
      if (state_d == S_WR_CFG) wdata_d = {4'h1, 22'd0, idx_d};
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= 1'b0;
      tmo_q     <= '0;
      poll_q    <= '0;
      sel_q     <= 1'b0;
      idx_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      err_q     <= E_OK;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_strb_q <= 1'b0;
      rd_strb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
      poll_q    <= poll_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_strb_q <= wr_strb_d;
      rd_strb_q <= rd_strb_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = (state_q == S_RESP);
  assign resp_data      = {hi_q, lo_q};
  assign resp_err       = err_q;
  assign rbus_addr_o    = addr_q;
  assign rbus_wr_data_o = wdata_q;
  assign rbus_wr_strb_o = wr_strb_q;
  assign rbus_rd_strb_o = rd_strb_q;

endmodule

// File: tb/tb_cr_cceip_64_sa_rbus_reader.sv
// Randomized scoreboard bench: a driver issues requests and pushes the
// expected result, a behavioural rbus responder serves accesses, and a
// monitor pops and compares whenever a response is presented.
module tb_cr_cceip_64_sa_rbus_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_sel;
  logic [5:0]  req_idx;
  logic        resp_valid, resp_ready;
  logic [49:0] resp_data;
  logic [1:0]  resp_err;
  logic [19:0] rbus_addr_o;
  logic        rbus_wr_strb_o, rbus_rd_strb_o;
  logic [31:0] rbus_wr_data_o, rbus_rd_data_i;
  logic        rbus_ack_i, rbus_err_ack_i;

  cr_cceip_64_sa_rbus_reader dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_idx(req_idx),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .rbus_addr_o(rbus_addr_o), .rbus_wr_strb_o(rbus_wr_strb_o), .rbus_wr_data_o(rbus_wr_data_o),
    .rbus_rd_strb_o(rbus_rd_strb_o), .rbus_rd_data_i(rbus_rd_data_i),
    .rbus_ack_i(rbus_ack_i), .rbus_err_ack_i(rbus_err_ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [49:0] data;
    logic [1:0]  err;
    int          nstat;
    int          nacc;
    logic [19:0] caddr;
    logic [31:0] cdata;
    int          lat;
    int          stall;
  } exp_t;

  exp_t sb[$];

  // responder configuration and per-request observations
  int          r_busy, r_lat;
  logic [31:0] r_d0, r_d1;
  bit          r_noack, r_erra;
  logic [19:0] cur_base;
  int          n_acc, n_stat, n_bad;
  logic [19:0] cfg_addr;
  logic [31:0] cfg_data;

  logic [19:0] s_a;
  logic [31:0] s_rd;
  bit          s_ack, s_err;

  // Remote SA register block: serves one access at a time, injects stray acks
  initial begin
    rbus_ack_i = 1'b0; rbus_err_ack_i = 1'b0; rbus_rd_data_i = '0;
    forever begin
      @(negedge clk);
      rbus_ack_i = 1'b0; rbus_err_ack_i = 1'b0;
      if (rst) continue;
      if (rbus_wr_strb_o || rbus_rd_strb_o) begin
        n_acc++;
        s_a = rbus_addr_o; s_rd = $urandom; s_ack = 1'b1; s_err = 1'b0;
        if (rbus_wr_strb_o && rbus_rd_strb_o) n_bad++;
        if (rbus_wr_strb_o) begin
          cfg_addr = s_a; cfg_data = rbus_wr_data_o;
          if (s_a != cur_base) n_bad++;
          s_ack = !r_noack;
        end else if (s_a == cur_base + 20'd4) begin
          n_stat++;
          if (n_stat <= r_busy) s_rd[31:29] = 3'($urandom_range(7, 1));
          else s_rd[31:29] = 3'd0;
        end else if (s_a == cur_base + 20'd8) begin
          s_rd = r_d0; s_err = r_erra;
        end else if (s_a == cur_base + 20'd12) begin
          s_rd = r_d1;
        end else begin
          n_bad++;
        end
        if (s_ack || s_err) begin
          repeat (r_lat) begin
            @(negedge clk);
            if (rbus_wr_strb_o || rbus_rd_strb_o) n_bad++;
          end
          rbus_ack_i = s_ack; rbus_err_ack_i = s_err; rbus_rd_data_i = s_rd;
        end
      end else if ((req_ready || resp_valid) && $urandom_range(3, 0) == 0) begin
        rbus_ack_i = 1'b1; rbus_rd_data_i = $urandom;
      end
    end
  end

  exp_t        m_e;
  logic [49:0] m_d;
  logic [1:0]  m_r;

  // Monitor: pop and compare on each presented response
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !resp_valid) continue;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
        resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
        continue;
      end
      m_e = sb.pop_front();
      if (m_e.lat >= 0) chk("latency", 64'(cyc - acc_cyc), 64'(m_e.lat));
      m_d = resp_data; m_r = resp_err;
      for (int i = 0; i < m_e.stall; i++) begin
        @(negedge clk);
        chk("hold_stable", {10'd0, resp_valid, req_ready, resp_err, resp_data},
            {10'd0, 1'b1, 1'b0, m_r, m_d});
      end
      chk("resp_data", 64'(resp_data), 64'(m_e.data));
      chk("resp_err", 64'(resp_err), 64'(m_e.err));
      chk("n_status", 64'(n_stat), 64'(m_e.nstat));
      chk("n_access", 64'(n_acc), 64'(m_e.nacc));
      chk("cfg_addr", 64'(cfg_addr), 64'(m_e.caddr));
      chk("cfg_data", 64'(cfg_data), 64'(m_e.cdata));
      chk("bad_access", 64'(n_bad), 64'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("after_handshake", {62'd0, resp_valid, req_ready}, 64'd1);
    end
  end

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (!req_ready) begin
      if (++w > 2000) begin
        $display("FAIL idle_timeout got=busy exp=idle");
        errors++;
        $fatal(1, "idle wait expired");
      end
      @(negedge clk);
    end
  endtask

  // Driver: configure responder, build expectation from the access rules, issue
  task automatic run_req(input bit sel, input logic [5:0] idx, input int busy, input int lat,
                         input logic [31:0] d0, input logic [31:0] d1, input bit noack,
                         input bit erra, input int stall, input int elat, input bit push);
    exp_t e;
    wait_idle();
    r_busy = busy; r_lat = lat; r_d0 = d0; r_d1 = d1; r_noack = noack; r_erra = erra;
    cur_base = sel ? 20'h00120 : 20'h00100;
    n_acc = 0; n_stat = 0; n_bad = 0; cfg_addr = '0; cfg_data = '0;
    e.caddr = cur_base;
    e.cdata = 32'h10000000 | {26'd0, idx};
    e.lat = elat;
    e.stall = stall;
    if (noack) begin
      e.err = 2'd2; e.data = '0; e.nstat = 0; e.nacc = 1;
    end else if (busy >= 15) begin
      e.err = 2'd3; e.data = '0; e.nstat = 15; e.nacc = 16;
    end else if (erra) begin
      e.err = 2'd1; e.data = '0; e.nstat = busy + 1; e.nacc = busy + 3;
    end else begin
      e.err = 2'd0; e.data = {d1[17:0], d0}; e.nstat = busy + 1; e.nacc = busy + 4;
    end
    if (push) sb.push_back(e);
    req_sel = sel; req_idx = idx; req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0; req_sel = 1'($urandom); req_idx = 6'($urandom);
  endtask

  int a0, w;

  initial begin
    req_valid = 1'b0; req_sel = 1'b0; req_idx = '0;
    r_busy = 0; r_lat = 1; r_d0 = '0; r_d1 = '0; r_noack = 0; r_erra = 0;
    cur_base = 20'h00100; n_acc = 0; n_stat = 0; n_bad = 0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {58'd0, req_ready, resp_valid, resp_err, rbus_wr_strb_o, rbus_rd_strb_o}, 64'h20);
    chk("reset_data", 64'(resp_data), 64'd0);
    chk("reset_bus", {12'd0, rbus_addr_o, rbus_wr_data_o}, 64'd0);
    rst = 1'b0;

    run_req(1'b0, 6'd5, 0, 1, 32'hDEADBEEF, 32'hFFFC0003, 0, 0, 0, 8, 1);
    run_req(1'b1, 6'd63, 3, 1, $urandom, $urandom, 0, 0, 1, -1, 1);
    run_req(1'b0, 6'($urandom), 1000, 1, $urandom, $urandom, 0, 0, 0, -1, 1);
    run_req(1'b1, 6'd17, 0, 1, $urandom, $urandom, 1, 0, 5, 256, 1);
    run_req(1'b0, 6'd33, 2, 2, $urandom, $urandom, 0, 1, 0, -1, 1);
    run_req(1'b1, 6'd40, 1, 1, $urandom, $urandom, 0, 0, 10, -1, 1);

    // reset while waiting on a STATUS read
    run_req(1'b1, 6'd9, 1000, 2, $urandom, $urandom, 0, 0, 0, -1, 0);
    w = 0;
    while (n_stat < 2) begin
      if (++w > 500) begin
        $display("FAIL status_wait got=%0d exp=2", n_stat);
        errors++;
        $fatal(1, "status wait expired");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_ctrl", {58'd0, req_ready, resp_valid, resp_err, rbus_wr_strb_o, rbus_rd_strb_o}, 64'h20);
    chk("async_reset_bus", {12'd0, rbus_addr_o, rbus_wr_data_o}, 64'd0);
    chk("async_reset_data", 64'(resp_data), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    a0 = n_acc;
    repeat (12) @(negedge clk);
    chk("no_strobe_after_reset", 64'(n_acc), 64'(a0));
    run_req(1'b0, 6'd12, 1, 1, $urandom, $urandom, 0, 0, 0, -1, 1);

    for (int i = 0; i < 20; i++)
      run_req(1'($urandom), 6'($urandom), $urandom_range(4, 0), $urandom_range(3, 1),
              $urandom, $urandom, 0, ($urandom_range(7, 0) == 0), $urandom_range(3, 0), -1, 1);

    wait_idle();
    w = 0;
    while (sb.size() != 0 || !req_ready) begin
      if (++w > 2000) begin
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
